// File: rtl/store_merge_unit.sv
// Narrows a 32-bit store to byte/halfword/word and merges it into word-wide memory via read-modify-write.
// Optional sign-extension overflow flag on narrow stores: define STORE_NARROW_CHECK_EN.
module store_merge_unit #(
   parameter int ADDR_W     = 10,
   parameter int RD_TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              StValid,
   output logic              StReady,
   input  logic [31:0]       StAddr,
   input  logic [31:0]       StData,
   input  logic [1:0]        StSize,
   output logic              Busy,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemRdEn,
   input  logic [31:0]       MemRdData,
   input  logic              MemRdValid,
   output logic              MemWrEn,
   output logic [31:0]       MemWrData,
   output logic              Done,
   output logic              Err,
   output logic              Ovf
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

   state_t           state;
   logic [31:0]      latData;
   logic [1:0]       latSize;
   logic [1:0]       latLane;
   logic [CNT_W-1:0] rdCount;
   logic             illegal;
   logic [31:0]      merged;

   assign illegal = (StSize == 2'b11) ||
                    (StSize == 2'b01 && StAddr[0]) ||
                    (StSize == 2'b10 && StAddr[1:0] != 2'b00);

   // Memory has no byte enables, so the stored lane is spliced into the word just read.
   always_comb begin
      merged = MemRdData;
      if (latSize == 2'b00) begin
         case (latLane)
            2'd0:    merged[7:0]   = latData[7:0];
            2'd1:    merged[15:8]  = latData[7:0];
            2'd2:    merged[23:16] = latData[7:0];
            default: merged[31:24] = latData[7:0];
         endcase
      end else if (latLane[1]) begin
         merged[31:16] = latData[15:0];
      end else begin
         merged[15:0] = latData[15:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         StReady   <= 1'b1;
         Busy      <= 1'b0;
         MemAddr   <= '0;
         MemRdEn   <= 1'b0;
         MemWrEn   <= 1'b0;
         MemWrData <= '0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         rdCount   <= '0;
         latData   <= '0;
         latSize   <= '0;
         latLane   <= '0;
      end else begin
         MemRdEn   <= 1'b0;
         MemWrEn   <= 1'b0;
         MemWrData <= '0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         case (state)
            IDLE: begin
               if (StValid && StReady) begin
                  latData <= StData;
                  latSize <= StSize;
                  latLane <= StAddr[1:0];
                  MemAddr <= StAddr[ADDR_W+1:2];
                  StReady <= 1'b0;
                  Busy    <= 1'b1;
                  if (illegal) begin
                     state <= ERR;
                     Done  <= 1'b1;
                     Err   <= 1'b1;
                  end else if (StSize == 2'b10) begin
                     state     <= WRITE;
                     MemWrEn   <= 1'b1;
                     MemWrData <= StData;
                     Done      <= 1'b1;
                  end else begin
                     state   <= READ;
                     MemRdEn <= 1'b1;
                  end
               end
            end
            READ: begin
               state   <= WAIT;
               rdCount <= '0;
            end
            // Read data arriving in the last allowed cycle still wins over the timeout.
            WAIT: begin
               if (MemRdValid) begin
                  state     <= WRITE;
                  MemWrEn   <= 1'b1;
                  MemWrData <= merged;
                  Done      <= 1'b1;
               end else begin
                  rdCount <= rdCount + CNT_W'(1);
                  if (rdCount == CNT_W'(RD_TIMEOUT - 1)) begin
                     state <= ERR;
                     Done  <= 1'b1;
                     Err   <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               StReady <= 1'b1;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef STORE_NARROW_CHECK_EN
   logic ovfNext;
   logic unusedAddr;

   assign unusedAddr = ^StAddr[31:ADDR_W+2];

   always_comb begin
      ovfNext = 1'b0;
      if (latSize == 2'b00)
         ovfNext = ({{24{latData[7]}}, latData[7:0]} != latData);
      else if (latSize == 2'b01)
         ovfNext = ({{16{latData[15]}}, latData[15:0]} != latData);
   end

   // Flag is informational only; it rides along with the Done of a successful narrow write.
   always_ff @(posedge Clk) begin
      if (Reset)
         Ovf <= 1'b0;
      else
         Ovf <= (state == WAIT && MemRdValid) ? ovfNext : 1'b0;
   end
`else
   logic unusedBits;

   assign unusedBits = ^{StAddr[31:ADDR_W+2], latData[31:16]};
   assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: per-cycle expected outputs from a transaction-level model.
module tb_store_merge_unit;

   localparam int ADDR_W     = 10;
   localparam int RD_TIMEOUT = 15;

   logic              Clk = 1'b0;
   logic              Reset, StValid, StReady, Busy;
   logic [31:0]       StAddr, StData, MemRdData, MemWrData;
   logic [1:0]        StSize;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemRdEn, MemRdValid, MemWrEn, Done, Err, Ovf;

   store_merge_unit #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .Clk(Clk), .Reset(Reset), .StValid(StValid), .StReady(StReady),
      .StAddr(StAddr), .StData(StData), .StSize(StSize), .Busy(Busy),
      .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemRdData(MemRdData),
      .MemRdValid(MemRdValid), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
      .Done(Done), .Err(Err), .Ovf(Ovf)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic              chk, rdy, busy, rdEn, wrEn, done, err, ovf;
      logic [31:0]       wrData;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   exp_t              expQ[$];
   string             nameQ[$];
   int                checks = 0;
   int                errors = 0;
   logic [ADDR_W-1:0] curAddr = '0;

   function automatic exp_t baseExp(input bit busy);
      exp_t e;
      e      = '0;
      e.chk  = 1'b1;
      e.rdy  = !busy;
      e.busy = busy;
      e.addr = curAddr;
      return e;
   endfunction

   // Little-endian byte-array view of the merge.
   function automatic logic [31:0] mergeModel(input logic [31:0] rd, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [31:0] a);
      logic [7:0] b [4];
      int lane;
      for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
      lane = int'(a[1:0]);
      b[lane] = d[7:0];
      if (sz == 2'b01) b[lane+1] = d[15:8];
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic bit ovfModel(input logic [31:0] d, input logic [1:0] sz);
      int sv;
      sv = $signed(d);
      if (sz == 2'b00) return (sv < -128) || (sv > 127);
      if (sz == 2'b01) return (sv < -32768) || (sv > 32767);
      return 1'b0;
   endfunction

   task automatic tick(input exp_t e, input string name);
      @(posedge Clk);
      #1;
      expQ.push_back(e);
      nameQ.push_back(name);
   endtask

   task automatic driveJunk();
      StValid    = 1'($urandom_range(0, 1));
      StAddr     = $urandom;
      StData     = $urandom;
      StSize     = 2'($urandom_range(0, 3));
      MemRdValid = 1'($urandom_range(0, 1));
      MemRdData  = $urandom;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick(baseExp(1'b0), "idle");
         StValid    = 1'b0;
         MemRdValid = 1'($urandom_range(0, 1));
         MemRdData  = $urandom;
      end
   endtask

   task automatic checkOutput(input exp_t e, input string n);
      logic [48:0] act, req;
      act = {StReady, Busy, MemRdEn, MemWrEn, Done, Err, Ovf, MemWrData, MemAddr};
      req = {e.rdy, e.busy, e.rdEn, e.wrEn, e.done, e.err, e.ovf, e.wrData, e.addr};
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got rdy=%0b busy=%0b rd=%0b wr=%0b done=%0b err=%0b ovf=%0b data=%08h addr=%0h, expected rdy=%0b busy=%0b rd=%0b wr=%0b done=%0b err=%0b ovf=%0b data=%08h addr=%0h",
                  n, StReady, Busy, MemRdEn, MemWrEn, Done, Err, Ovf, MemWrData, MemAddr,
                  e.rdy, e.busy, e.rdEn, e.wrEn, e.done, e.err, e.ovf, e.wrData, e.addr);
      end
   endtask

   always @(negedge Clk) begin
      if (expQ.size() > 0) begin
         exp_t  e;
         string n;
         e = expQ.pop_front();
         n = nameQ.pop_front();
         if (e.chk) checkOutput(e, n);
      end
   end

   // One complete request; lat is the WAIT cycle that returns data, -1 for none.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz,
                                input logic [31:0] rdWord, input int lat, input bit useLit,
                                input logic [31:0] litWr, input bit litOvf, input string name);
      exp_t e;
      bit   illegal;
      illegal = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      tick(baseExp(1'b0), {name, " accept"});
      StValid    = 1'b1;
      StAddr     = addr;
      StData     = data;
      StSize     = sz;
      MemRdValid = 1'($urandom_range(0, 1));
      MemRdData  = $urandom;
      curAddr    = addr[ADDR_W+1:2];
      if (illegal) begin
         e = baseExp(1'b1); e.done = 1'b1; e.err = 1'b1;
         tick(e, {name, " err"});
         driveJunk();
      end else if (sz == 2'b10) begin
         e = baseExp(1'b1); e.wrEn = 1'b1; e.done = 1'b1;
         e.wrData = useLit ? litWr : data;
         tick(e, {name, " write"});
         driveJunk();
      end else begin
         e = baseExp(1'b1); e.rdEn = 1'b1;
         tick(e, {name, " read"});
         driveJunk();
         for (int k = 0; k < RD_TIMEOUT; k++) begin
            tick(baseExp(1'b1), {name, " wait"});
            StValid    = 1'($urandom_range(0, 1));
            MemRdValid = (k == lat);
            MemRdData  = (k == lat) ? rdWord : $urandom;
            if (k == lat) break;
         end
         e = baseExp(1'b1);
         e.done = 1'b1;
         if (lat >= 0) begin
            e.wrEn   = 1'b1;
            e.wrData = useLit ? litWr : mergeModel(rdWord, data, sz, addr);
`ifdef STORE_NARROW_CHECK_EN
            e.ovf    = useLit ? litOvf : ovfModel(data, sz);
`endif
         end else begin
            e.err = 1'b1;
         end
         tick(e, {name, " retire"});
         driveJunk();
      end
   endtask

   task automatic resetMidWait();
      exp_t e;
      tick(baseExp(1'b0), "rst accept");
      StValid = 1'b1; StAddr = 32'h0000_0021; StData = 32'h77; StSize = 2'b00; MemRdValid = 1'b0;
      curAddr = 10'h008;
      e = baseExp(1'b1); e.rdEn = 1'b1;
      tick(e, "rst read");
      StValid = 1'b0; MemRdValid = 1'b0;
      tick(baseExp(1'b1), "rst wait0");
      tick(baseExp(1'b1), "rst wait1");
      Reset = 1'b1;
      curAddr = '0;
      tick(baseExp(1'b0), "rst held");
      tick(baseExp(1'b0), "rst released");
      Reset = 1'b0; MemRdValid = 1'b1; MemRdData = 32'hCAFE_F00D;
      tick(baseExp(1'b0), "rst late valid");
      tick(baseExp(1'b0), "rst no write");
      MemRdValid = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; StValid = 1'b0; StAddr = '0; StData = '0; StSize = '0;
      MemRdValid = 1'b0; MemRdData = '0;
      tick('0, "startup");
      tick(baseExp(1'b0), "reset state");
      Reset = 1'b0;
      idleCycles(2);

      applyStimulus(32'h10, 32'hDEADBEEF, 2'b10, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0, "word");
      idleCycles(1);
      applyStimulus(32'h13, 32'h0000_00A5, 2'b00, 32'h1122_3344, 1, 1'b1, 32'hA522_3344, 1'b1, "byte");
      applyStimulus(32'h06, 32'hFFFF_8001, 2'b01, 32'h1122_3344, 0, 1'b1, 32'h8001_3344, 1'b0, "half");
      applyStimulus(32'h06, 32'h0000_8001, 2'b01, 32'h1122_3344, 2, 1'b1, 32'h8001_3344, 1'b1, "half ovf");
      applyStimulus(32'h05, 32'h1234, 2'b01, 32'h0, 0, 1'b0, 32'h0, 1'b0, "misaligned");
      applyStimulus(32'h10, 32'h1234, 2'b11, 32'h0, 0, 1'b0, 32'h0, 1'b0, "illegal size");
      applyStimulus(32'h22, 32'h5A, 2'b00, 32'h0, -1, 1'b0, 32'h0, 1'b0, "timeout");
      idleCycles(1);
      applyStimulus(32'h22, 32'h5A, 2'b00, 32'hAABB_CCDD, RD_TIMEOUT - 1, 1'b1, 32'hAA5A_CCDD, 1'b0, "last cycle");
      resetMidWait();
      idleCycles(1);

      for (int t = 0; t < 300; t++) begin
         logic [31:0] a, d;
         logic [1:0]  sz;
         int          sel, lat;
         a   = $urandom;
         sz  = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 2);
         d   = (sel == 0) ? $urandom : (sel == 1) ? {{24{1'($urandom_range(0, 1))}}, 8'($urandom)}
                                                  : {{16{1'($urandom_range(0, 1))}}, 16'($urandom)};
         if ($urandom_range(0, 1) == 1) a[1:0] = (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
         sel = $urandom_range(0, 9);
         lat = (sel == 0) ? -1 : (sel == 1) ? RD_TIMEOUT - 1 : $urandom_range(0, 4);
         applyStimulus(a, d, sz, $urandom, lat, 1'b0, 32'h0, 1'b0, "random");
         idleCycles($urandom_range(0, 2));
      end
      idleCycles(2);
      @(posedge Clk);
      #6;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load-path sign extender. Load path widens byte/halfword to 32 bits; this block narrows a 32-bit register value to byte/halfword/word and writes it into word-wide data memory.
- Data memory has no byte enables, so narrow stores use a read-modify-write sequence.
- Sits between the MEM pipeline stage and data memory. Busy stalls the pipeline while a store is in flight.

Parameters:
- ADDR_W, 10, word-address width driven to data memory.
- RD_TIMEOUT, 15, maximum cycles to wait for MemRdValid before aborting; at least 1.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- StValid  in  1  store request valid.
- StReady  out  1  block can accept a request; high only in IDLE.
- StAddr  in  32  byte address.
- StData  in  32  register value to store.
- StSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Busy  out  1  high in every state except IDLE.
- MemAddr  out  ADDR_W  word address, StAddr[ADDR_W+1:2] latched at accept.
- MemRdEn  out  1  one-cycle read request.
- MemRdData  in  32  read data.
- MemRdValid  in  1  read data valid; ignored outside WAIT.
- MemWrEn  out  1  one-cycle write strobe.
- MemWrData  out  32  merged write word.
- Done  out  1  one-cycle pulse when a request retires.
- Err  out  1  one-cycle pulse with Done on misalignment, illegal size or read timeout.
- Ovf  out  1  see Optional Feature.

Behaviour:
- Reset: state IDLE. All outputs 0 except StReady=1. Timeout counter 0. Applies from any state; any in-flight read is abandoned and its late MemRdValid is ignored.
- Accept: StValid && StReady on edge T. Latch address, data and size.
- States: IDLE, READ, WAIT, WRITE, ERR.
  - IDLE: on accept, go to ERR if illegal, WRITE if word, READ if byte or halfword.
  - READ: MemRdEn=1 for exactly one cycle, then WAIT.
  - WAIT: on MemRdValid, latch MemRdData and go to WRITE. Otherwise increment the counter; when it reaches RD_TIMEOUT, go to ERR.
  - WRITE: MemWrEn=1 and Done=1 for one cycle, then IDLE.
  - ERR: Done=1 and Err=1 for one cycle with no memory write, then IDLE.
- Illegal requests: StSize=11, halfword with StAddr[0]=1, or word with StAddr[1:0]!=0.
- Lane rules (little-endian): merged word = read word with the selected lane replaced; other bits unchanged.
  - Byte: StData[7:0] replaces lane StAddr[1:0], bits [8k+7:8k].
  - Halfword: StData[15:0] replaces bits [15:0] if StAddr[1]=0, else [31:16].
  - Word: MemWrData=StData, no read.
- Upper StData bits beyond the stored width are discarded.
- Latency:
  - Word store: MemWrEn and Done at T+1.
  - Narrow store: MemRdEn at T+1; MemRdValid earliest T+2; MemWrEn and Done one cycle after MemRdValid.
  - Error: Done and Err at T+1.
- Timeout: counter clears on entry to WAIT.
- Simultaneous events: MemRdValid in the same cycle the counter reaches RD_TIMEOUT counts as success (data wins).
- Back-to-back: StReady returns high the cycle after Done. No request is accepted in the Done cycle.
- MemAddr holds its latched value until the next accept.
- MemWrData is 0 whenever MemWrEn=0.

Optional Feature:
- Macro: STORE_NARROW_CHECK_EN.
- Defined: Ovf pulses with Done, for any successful narrow store, when the sign extension of the stored field differs from StData.
  - Byte: {{24{StData[7]}},StData[7:0]} != StData.
  - Halfword: {{16{StData[15]}},StData[15:0]} != StData.
  - Word: never.
  - The write still occurs; Ovf is informational.
- Undefined: Ovf tied to 0; no check logic synthesized.

Test Plan:
- Reset: assert Reset for 2 cycles mid-WAIT, then drive MemRdValid=1 -> no MemWrEn; StReady=1, Busy=0, all other outputs 0.
- Word store: StAddr=0x0000_0010, StData=0xDEADBEEF, StSize=10 -> MemWrEn, Done at T+1; MemAddr=4; MemWrData=0xDEADBEEF; MemRdEn never asserted.
- Byte store: StAddr=0x0000_0013, StData=0x0000_00A5, memory returns 0x11223344 at T+3 -> MemWrEn at T+4 with MemWrData=0xA5223344, Done=1.
- Halfword store: StAddr=0x0000_0006, StData=0xFFFF_8001, memory returns 0x11223344 -> MemWrData=0x80013344. With STORE_NARROW_CHECK_EN: Ovf=0. Repeat with StData=0x0000_8001 -> Ovf=1.
- Misaligned: halfword at StAddr=0x0000_0005 -> Done=Err=1 at T+1, no MemRdEn or MemWrEn. Same result for StSize=11.
- Timeout: byte store, MemRdValid held 0 -> Err=Done=1 exactly RD_TIMEOUT cycles after entering WAIT, then StReady=1. Repeat with MemRdValid in the final cycle -> normal write, Err=0.
